control_sequencer: RTL and testbench

- Hardwired Moore control unit directly upstream of the datapath.
- Runs the fetch sequence T0–T2, then decodes the IR input and sequences execute steps for register ALU, neg/not, mul/div, nop and halt.
- Its outputs replace the per-state control vectors that benches currently drive by hand.
- Drives the datapath's control inputs one-to-one by name.

---
 rtl/cpu_defs.sv | 103 ++++++++++
 rtl/reg_select_decoder.sv | 18 +
 rtl/control_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the control sequencer: instruction field positions,
// opcodes, ALU function codes, state encoding and opcode classification.
package cpu_defs;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_ROR  = 4'd4;
  localparam logic [3:0] ALU_ROL  = 4'd5;
  localparam logic [3:0] ALU_SHR  = 4'd6;
  localparam logic [3:0] ALU_SHRA = 4'd7;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_NEG  = 4'd10;
  localparam logic [3:0] ALU_NOT  = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;

  typedef enum logic [3:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALTED
  } state_e;

  // Execute-step families; every opcode maps onto exactly one.
  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ALU3,
    CLS_UNARY,
    CLS_MULDIV,
    CLS_HALT
  } op_class_e;

  // Which IR register field drives the Rout decoder.
  typedef enum logic [1:0] {
    RSEL_RA,
    RSEL_RB,
    RSEL_RC
  } rsel_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       op_class = CLS_ALU3;
      OP_NEG, OP_NOT:                         op_class = CLS_UNARY;
      OP_MUL, OP_DIV:                         op_class = CLS_MULDIV;
      OP_HALT:                                op_class = CLS_HALT;
      OP_NOP:                                 op_class = CLS_NONE;
      default:                                op_class = CLS_NONE;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      OP_ROR:  alu_code = ALU_ROR;
      OP_ROL:  alu_code = ALU_ROL;
      OP_SHR:  alu_code = ALU_SHR;
      OP_SHRA: alu_code = ALU_SHRA;
      OP_SHL:  alu_code = ALU_SHL;
      OP_MUL:  alu_code = ALU_MUL;
      OP_DIV:  alu_code = ALU_DIV;
      OP_NEG:  alu_code = ALU_NEG;
      OP_NOT:  alu_code = ALU_NOT;
      default: alu_code = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register index to one-hot select, gated by an enable.
module reg_select_decoder #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  // One bit per register; all zero when not enabled.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = en_i && (idx_i == IDX_W'(i));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, then execute steps chosen by
// the opcode in IR. Outputs depend on the state register and IR fields only.
//
// state   | meaning
// --------+----------------------------------------------------------
// RST     | held by clear; all outputs 0
// T0      | PC to MAR, PC+1 into Z
// T1      | PC <- Z, memory read into MDR
// T2      | MDR into IR
// T3..T6  | execute steps, content depends on opcode class
// HALTED  | absorbing; all outputs 0 until clear
module control_sequencer
  import cpu_defs::*;
#(
  parameter int RF_SIZE = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [31:0]        IR,
  input  logic               Stop,
  output logic [RF_SIZE-1:0] Rin,
  output logic [RF_SIZE-1:0] Rout,
  output logic               PCin,
  output logic               PCout,
  output logic               IncPC,
  output logic               MARin,
  output logic               MDRin,
  output logic               MDRout,
  output logic               IRin,
  output logic               Yin,
  output logic               Zlowin,
  output logic               Zhighin,
  output logic               Zlowout,
  output logic               Zhighout,
  output logic               HIin,
  output logic               LOin,
  output logic               Read,
  output logic [3:0]         ALUop,
  output logic               Run
);

  state_e    state_q, state_d;
  state_e    end_next;
  logic      stop_req_q, stop_req_d;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic [3:0] rout_idx;
  logic [3:0] alu_sel;
  op_class_e  cls;
  rsel_e      rout_sel;
  logic       rin_en, rout_en;
  logic       unused_ir;

  assign op        = IR[OP_MSB:OP_LSB];
  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign cls       = op_class(op);
  assign alu_sel   = alu_code(op);
  assign unused_ir = ^IR[RC_LSB-1:0];

  // A pending stop request diverts the end of the current instruction.
  assign end_next = stop_req_q ? ST_HALTED : ST_T0;

  // State and stop request registers; clear abandons everything at once.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= ST_RST;
      stop_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stop_req_q <= stop_req_d;
    end
  end

  // Stop is remembered from any edge while the sequencer is active.
  always_comb begin
    stop_req_d = stop_req_q |
                 (Stop && (state_q != ST_RST) && (state_q != ST_HALTED));
  end

  // Next-state: fetch is fixed, execute length follows the opcode class.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  state_d = ST_T2;
      ST_T2:  state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_HALT:   state_d = ST_HALTED;
          CLS_NONE:   state_d = end_next;
          default:    state_d = ST_T4;
        endcase
      end
      ST_T4: begin
        if (cls == CLS_ALU3 || cls == CLS_MULDIV) state_d = ST_T5;
        else                                      state_d = end_next;
      end
      ST_T5: begin
        if (cls == CLS_MULDIV) state_d = ST_T6;
        else                   state_d = end_next;
      end
      ST_T6:     state_d = end_next;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RST;
    endcase
  end

  // Moore output decode; register strobes go through the one-hot decoders.
  always_comb begin
    PCin     = 1'b0;
    PCout    = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Read     = 1'b0;
    ALUop    = ALU_ADD;
    Run      = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = RSEL_RA;
    case (state_q)
      ST_T0: begin
        Run    = 1'b1;
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      ST_T1: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        Run = 1'b1;
        case (cls)
          CLS_ALU3: begin
            rout_en  = 1'b1;
            rout_sel = RSEL_RB;
            Yin      = 1'b1;
          end
          CLS_UNARY: begin
            rout_en  = 1'b1;
            rout_sel = RSEL_RB;
            ALUop    = alu_sel;
            Zlowin   = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en  = 1'b1;
            rout_sel = RSEL_RA;
            Yin      = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        Run = 1'b1;
        case (cls)
          CLS_ALU3: begin
            rout_en  = 1'b1;
            rout_sel = RSEL_RC;
            ALUop    = alu_sel;
            Zlowin   = 1'b1;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1;
            rin_en  = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en  = 1'b1;
            rout_sel = RSEL_RB;
            ALUop    = alu_sel;
            Zlowin   = 1'b1;
            Zhighin  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        Run = 1'b1;
        case (cls)
          CLS_ALU3: begin
            Zlowout = 1'b1;
            rin_en  = 1'b1;
          end
          CLS_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        Run = 1'b1;
        if (cls == CLS_MULDIV) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Rout source register differs per execute step.
  always_comb begin
    case (rout_sel)
      RSEL_RB: rout_idx = rb;
      RSEL_RC: rout_idx = rc;
      default: rout_idx = ra;
    endcase
  end

  reg_select_decoder #(.N(RF_SIZE), .IDX_W(4)) u_rin_dec (
    .idx_i    (ra),
    .en_i     (rin_en),
    .onehot_o (Rin)
  );

  reg_select_decoder #(.N(RF_SIZE), .IDX_W(4)) u_rout_dec (
    .idx_i    (rout_idx),
    .en_i     (rout_en),
    .onehot_o (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios with literal expectations,
// then randomized instruction streams checked every cycle against a
// step-table model of the instruction set.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        Stop;
  logic [15:0] Rin, Rout;
  logic        PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Read, Run;
  logic [3:0]  ALUop;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic [3:0]  aluop;
    logic pcin, pcout, incpc, marin, mdrin, mdrout, irin, yin;
    logic zlowin, zhighin, zlowout, zhighout, hiin, loin, read, run;
  } ctl_t;

  ctl_t act;
  assign act = {Rin, Rout, ALUop, PCin, PCout, IncPC, MARin, MDRin, MDRout,
                IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
                Read, Run};

  control_sequencer #(.RF_SIZE(16)) dut (
    .clock(clock), .clear(clear), .IR(IR), .Stop(Stop),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Read(Read),
    .ALUop(ALUop), .Run(Run)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  bit done    = 1'b0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Execute length of an instruction in cycles, fetch included.
  function automatic int ilen(input logic [31:0] ir);
    int op;
    op = int'(ir[31:27]);
    if (op >= 3 && op <= 11)      return 6;
    if (op == 17 || op == 18)     return 5;
    if (op == 15 || op == 16)     return 7;
    return 4;
  endfunction

  // Expected control vector for step k of the instruction held in ir.
  function automatic ctl_t exp_out(input int k, input logic [31:0] ir);
    ctl_t e;
    int op, ra, rb, rc;
    logic [3:0] ac;
    e  = '0;
    e.run = 1'b1;
    op = int'(ir[31:27]);
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    case (k)
      0: begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zlowin = 1; end
      1: begin e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; end
      2: begin e.mdrout = 1; e.irin = 1; end
      default: begin
        if (op >= 3 && op <= 11) begin
          ac = 4'(op - 3);
          if (k == 3) begin e.rout = 16'd1 << rb; e.yin = 1; end
          if (k == 4) begin e.rout = 16'd1 << rc; e.aluop = ac; e.zlowin = 1; end
          if (k == 5) begin e.zlowout = 1; e.rin = 16'd1 << ra; end
        end else if (op == 17 || op == 18) begin
          ac = 4'(op - 7);
          if (k == 3) begin e.rout = 16'd1 << rb; e.aluop = ac; e.zlowin = 1; end
          if (k == 4) begin e.zlowout = 1; e.rin = 16'd1 << ra; end
        end else if (op == 15 || op == 16) begin
          ac = (op == 15) ? 4'd9 : 4'd12;
          if (k == 3) begin e.rout = 16'd1 << ra; e.yin = 1; end
          if (k == 4) begin
            e.rout = 16'd1 << rb; e.aluop = ac; e.zlowin = 1; e.zhighin = 1;
          end
          if (k == 5) begin e.zlowout = 1; e.loin = 1; end
          if (k == 6) begin e.zhighout = 1; e.hiin = 1; end
        end
      end
    endcase
    return e;
  endfunction

  // Model: 0 = reset, 1 = running at step m_k, 2 = halted.
  int m_mode = 0;
  int m_k    = 0;
  bit m_stop = 1'b0;

  always @(posedge clock) begin : model
    bit old_stop;
    if (clear) begin
      m_mode = 0; m_k = 0; m_stop = 1'b0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_k = 0; end
        1: begin
          old_stop = m_stop;
          if (Stop) m_stop = 1'b1;
          if (m_k == ilen(IR) - 1) begin
            if (int'(IR[31:27]) == 27 || old_stop) m_mode = 2;
            else m_k = 0;
          end else begin
            m_k++;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clock) begin : compare
    ctl_t e;
    if (!done) begin
      e = (clear || m_mode != 1) ? ctl_t'('0) : exp_out(m_k, IR);
      check("cycle_vs_model", act, e);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    int sel;
    r   = $urandom();
    sel = $urandom_range(0, 99);
    if (sel < 60)      r[31:27] = 5'($urandom_range(3, 11));
    else if (sel < 70) r[31:27] = 5'($urandom_range(17, 18));
    else if (sel < 80) r[31:27] = 5'($urandom_range(15, 16));
    else if (sel < 88) r[31:27] = 5'd26;
    else if (sel < 90) r[31:27] = 5'd27;
    return r;
  endfunction

  initial begin
    clear = 1'b1; Stop = 1'b0; IR = '0;

    check("model_neg_len", 64'(ilen(32'h8A380000)), 5);
    check("model_mul_t4_aluop", 64'(exp_out(4, 32'h79880000).aluop), 9);
    check("model_add_t5_rin", 64'(exp_out(5, 32'h192B0000).rin), 16'h0004);

    cyc();
    check("clear_all_zero", 64'(act), 0);
    #14;
    clear = 1'b0;
    cyc();
    check("t0_pcout", PCout, 1); check("t0_marin", MARin, 1);
    check("t0_incpc", IncPC, 1); check("t0_zlowin", Zlowin, 1);
    check("t0_run", Run, 1);

    IR = 32'h8A380000;
    repeat (3) cyc();
    check("neg_t3_rout", Rout, 16'h0080); check("neg_t3_alu", ALUop, 10);
    check("neg_t3_zlowin", Zlowin, 1);
    cyc();
    check("neg_t4_zlowout", Zlowout, 1); check("neg_t4_rin", Rin, 16'h0010);
    cyc();
    check("neg_then_t0", PCout, 1);

    IR = 32'h192B0000;
    repeat (3) cyc();
    check("add_t3_rout", Rout, 16'h0020); check("add_t3_yin", Yin, 1);
    cyc();
    check("add_t4_rout", Rout, 16'h0040); check("add_t4_alu", ALUop, 0);
    check("add_t4_zlowin", Zlowin, 1);
    cyc();
    check("add_t5_rin", Rin, 16'h0004); check("add_t5_zlowout", Zlowout, 1);
    cyc();
    check("add_then_t0", PCout, 1);

    IR = 32'h79880000;
    repeat (3) cyc();
    check("mul_t3_rout", Rout, 16'h0008); check("mul_t3_yin", Yin, 1);
    cyc();
    check("mul_t4_rout", Rout, 16'h0002); check("mul_t4_alu", ALUop, 9);
    check("mul_t4_zlowin", Zlowin, 1); check("mul_t4_zhighin", Zhighin, 1);
    cyc();
    check("mul_t5_loin", LOin, 1);
    cyc();
    check("mul_t6_hiin", HIin, 1); check("mul_t6_zhighout", Zhighout, 1);
    cyc();
    check("mul_then_t0", PCout, 1);

    IR = 32'hD0000000;
    repeat (3) cyc();
    check("nop_t3_regs", {Rin, Rout}, 0); check("nop_t3_run", Run, 1);
    cyc();
    check("nop_then_t0", PCout, 1);

    IR = 32'h192B0000;
    cyc();
    Stop = 1'b1;
    cyc();
    Stop = 1'b0;
    repeat (3) cyc();
    check("stop_add_t5_rin", Rin, 16'h0004);
    cyc();
    check("stop_halted_run", Run, 0); check("stop_halted_zero", 64'(act), 0);

    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc();
    check("restart_t0", PCout, 1); check("restart_run", Run, 1);

    repeat (4) cyc();
    check("abort_t4_zlowin", Zlowin, 1);
    #2 clear = 1'b1;
    #1 check("abort_zero_now", 64'(act), 0);
    cyc();
    check("abort_no_rin", Rin, 0);
    clear = 1'b0;
    cyc();
    check("abort_restart_t0", PCout, 1); check("abort_restart_run", Run, 1);

    IR = 32'hD8000000;
    repeat (3) cyc();
    check("halt_t3_run", Run, 1);
    cyc();
    for (int i = 0; i < 10; i++) begin
      check("halted_hold", 64'(act), 0);
      cyc();
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      cyc();
      if (clear) clear = 1'b0;
      else if ((m_mode == 2 && $urandom_range(0, 3) == 0) ||
               $urandom_range(0, 299) == 0) clear = 1'b1;
      Stop = ($urandom_range(0, 39) == 0);
      if ((m_mode != 1 || m_k <= 2) && $urandom_range(0, 1) == 0)
        IR = rand_ir();
    end

    @(posedge clock);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
